// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: RV32I byte/half/word requests mapped onto a word-only data memory.
// Optional MISALIGN_TRAP_EN turns misaligned H/W accesses into errors instead of clearing low bits.
module lsu_mem_ctrl #(
   parameter int unsigned          ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
   parameter int unsigned          MEM_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [31:0]       mem_read_data
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

   localparam logic [ADDR_W:0] MemWordsW = (ADDR_W+1)'(MEM_WORDS);

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [ADDR_W-1:0]   off_q, off_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rword_q, rword_d;
   logic                err_q, err_d;

   logic [ADDR_W-1:0]   req_off;
   logic                funct3_illegal;
   logic                range_err;
   logic                misalign_err;
   logic                req_err;
   logic [1:0]          lane;
   logic [ADDR_W-1:0]   word_addr;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [31:0]         load_data;
   logic [31:0]         merged;

   // Request decode, evaluated only when a request is being accepted in IDLE.
   assign req_off = req_addr - BASE_ADDR;

   always_comb begin
      funct3_illegal = 1'b1;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: funct3_illegal = 1'b0;
         3'b100, 3'b101:         funct3_illegal = req_we;
         default:                funct3_illegal = 1'b1;
      endcase
   end

   // Subtraction wraps modulo 2^ADDR_W, so underflow is caught by the explicit compare.
   assign range_err = ({1'b0, (req_off >> 2)} >= MemWordsW) || (req_addr < BASE_ADDR);

`ifdef MISALIGN_TRAP_EN
   assign misalign_err = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_off[1:0] != 2'b00));
`else
   assign misalign_err = 1'b0;
`endif

   assign req_err   = funct3_illegal || range_err || misalign_err;
   assign lane      = off_q[1:0];
   assign word_addr = {off_q[ADDR_W-1:2], 2'b00};

   // Halfword selection uses lane[1] only, which also clears lane[0] when misalignment is not trapped.
   assign byte_sel = rword_q[{lane, 3'b000} +: 8];
   assign half_sel = rword_q[{lane[1], 4'b0000} +: 16];

   always_comb begin
      load_data = rword_q;
      case (funct3_q)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {24'h000000, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_data = {16'h0000, half_sel};
         default: load_data = rword_q;
      endcase
   end

   always_comb begin
      merged = rword_q;
      case (funct3_q[1:0])
         2'b00:   merged[{lane, 3'b000} +: 8]      = wdata_q[7:0];
         2'b01:   merged[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      we_d           = we_q;
      funct3_d       = funct3_q;
      off_d          = off_q;
      wdata_d        = wdata_q;
      rword_d        = rword_q;
      err_d          = err_q;
      req_ready      = 1'b0;
      rsp_valid      = 1'b0;
      rsp_rdata      = 32'h0;
      rsp_err        = 1'b0;
      mem_address    = '0;
      mem_write_data = 32'h0;
      mem_write      = 1'b0;
      mem_read       = 1'b0;

      case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               off_d    = req_off;
               wdata_d  = req_wdata;
               err_d    = req_err;
               if (req_err) begin
                  state_d = StResp;
               end else if (!req_we || (req_funct3[1:0] != 2'b10)) begin
                  state_d = StRd;
               end else begin
                  state_d = StWr;
               end
            end
         end
         StRd: begin
            mem_read    = 1'b1;
            mem_address = word_addr;
            rword_d     = mem_read_data;
            state_d     = we_q ? StWr : StResp;
         end
         StWr: begin
            mem_write      = 1'b1;
            mem_address    = word_addr;
            mem_write_data = merged;
            state_d        = StResp;
         end
         StResp: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = (err_q || we_q) ? 32'h0 : load_data;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         off_q    <= '0;
         wdata_q  <= 32'h0;
         rword_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         wdata_q  <= wdata_d;
         rword_q  <= rword_d;
         err_q    <= err_d;
      end
   end

   a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_read && mem_write));
   a_rsp_pulse:  assert property (@(posedge clk) disable iff (!rst_n) rsp_valid |=> !rsp_valid);

endmodule
